cbfp_1: RTL and testbench

CBFP_1 -- requirements
Module: cbfp_1

---
 rtl/cbfp_1.sv | 191 +++++++++++++++++++
 tb/tb_cbfp_1.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_1.sv
// Block floating-point normalizer: finds the smallest redundant-sign-bit count
// over a BEATS-beat block, then replays the buffered block shifted by that amount.
module cbfp_1 #(
  parameter int IN_WIDTH  = 25,
  parameter int OUT_WIDTH = 13,
  parameter int BEATS     = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [IN_WIDTH-1:0]  twd_12_sum_re  [0:15],
  input  logic signed [IN_WIDTH-1:0]  twd_12_sum_im  [0:15],
  input  logic signed [IN_WIDTH-1:0]  twd_12_diff_re [0:15],
  input  logic signed [IN_WIDTH-1:0]  twd_12_diff_im [0:15],
  input  logic                        CBFP_valid,
  output logic signed [OUT_WIDTH-1:0] cbfp_sum_re    [0:15],
  output logic signed [OUT_WIDTH-1:0] cbfp_sum_im    [0:15],
  output logic signed [OUT_WIDTH-1:0] cbfp_diff_re   [0:15],
  output logic signed [OUT_WIDTH-1:0] cbfp_diff_im   [0:15],
  output logic [4:0]                  cbfp_index,
  output logic                        cbfp_valid_out
);

  localparam int LANES = 64;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [4:0] LZ_MAX = 5'(IN_WIDTH - 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  // Redundant sign bits: how many bits below the MSB still equal the MSB.
  function automatic logic [4:0] lz(input logic [IN_WIDTH-1:0] x);
    logic [4:0] n;
    logic       run;
    n   = 5'd0;
    run = 1'b1;
    for (int i = IN_WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[IN_WIDTH-1])) n = n + 5'd1;
      else run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] norm(input logic [IN_WIDTH-1:0] x,
                                                       input logic [4:0] sh);
    logic [IN_WIDTH-1:0] t;
    t = x << sh;
    return t[IN_WIDTH-1 -: OUT_WIDTH];
  endfunction

  logic signed [IN_WIDTH-1:0]  beat_s [0:LANES-1];
  logic signed [IN_WIDTH-1:0]  mem_r  [0:1][0:BEATS-1][0:LANES-1];
  logic signed [OUT_WIDTH-1:0] out_r  [0:LANES-1];
  logic [4:0]    beat_min_s;
  logic [4:0]    acc_next_s;
  logic [4:0]    min_acc_r;
  logic [4:0]    idx_r [0:1];
  logic [BW-1:0] beat_cnt_r;
  logic [BW-1:0] rd_cnt_r;
  logic          wr_sel_r;
  logic          rd_sel_r;
  logic          pending_r;
  logic [0:0]    state_r;
  logic          block_done_s;
  logic          drain_last_s;

  // Flatten the four input arrays into one lane vector.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      beat_s[i]      = twd_12_sum_re[i];
      beat_s[16 + i] = twd_12_sum_im[i];
      beat_s[32 + i] = twd_12_diff_re[i];
      beat_s[48 + i] = twd_12_diff_im[i];
    end
  end

  // Minimum lz over the current beat, merged with the running block minimum.
  always_comb begin
    beat_min_s = LZ_MAX;
    for (int i = 0; i < LANES; i++) begin
      if (lz(beat_s[i]) < beat_min_s) beat_min_s = lz(beat_s[i]);
      else beat_min_s = beat_min_s;
    end
    if (beat_min_s < min_acc_r) acc_next_s = beat_min_s;
    else acc_next_s = min_acc_r;
  end

  assign block_done_s = CBFP_valid && (beat_cnt_r == LAST_BEAT);
  assign drain_last_s = (state_r == S_DRAIN) && (rd_cnt_r == LAST_BEAT);

  // Fill side: beat counter, ping-pong select and per-buffer block exponent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_r <= '0;
      wr_sel_r   <= 1'b0;
      min_acc_r  <= LZ_MAX;
      idx_r[0]   <= LZ_MAX;
      idx_r[1]   <= LZ_MAX;
    end else if (CBFP_valid) begin
      if (beat_cnt_r == LAST_BEAT) begin
        beat_cnt_r      <= '0;
        wr_sel_r        <= ~wr_sel_r;
        min_acc_r       <= LZ_MAX;
        idx_r[wr_sel_r] <= acc_next_s;
      end else begin
        beat_cnt_r <= beat_cnt_r + BW'(1);
        min_acc_r  <= acc_next_s;
      end
    end else begin
      beat_cnt_r <= beat_cnt_r;
      min_acc_r  <= min_acc_r;
    end
  end

  // Sample storage needs no reset; only fully written buffers are ever drained.
  always_ff @(posedge clk) begin
    if (CBFP_valid) begin
      for (int i = 0; i < LANES; i++) mem_r[wr_sel_r][beat_cnt_r][i] <= beat_s[i];
    end
  end

  // Drain FSM: replay one buffer, chaining straight into the next completed block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= S_IDLE;
      rd_sel_r  <= 1'b0;
      rd_cnt_r  <= '0;
      pending_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (block_done_s) begin
            state_r  <= S_DRAIN;
            rd_sel_r <= wr_sel_r;
            rd_cnt_r <= '0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (drain_last_s) begin
            rd_cnt_r  <= '0;
            pending_r <= 1'b0;
            if (block_done_s || pending_r) begin
              rd_sel_r <= ~rd_sel_r;
            end else begin
              state_r <= S_IDLE;
            end
          end else begin
            rd_cnt_r <= rd_cnt_r + BW'(1);
            if (block_done_s) pending_r <= 1'b1;
            else pending_r <= pending_r;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          rd_cnt_r  <= '0;
          pending_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered outputs, forced to zero outside of a drain beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cbfp_valid_out <= 1'b0;
      cbfp_index     <= 5'd0;
      for (int i = 0; i < LANES; i++) out_r[i] <= '0;
    end else if (state_r == S_DRAIN) begin
      cbfp_valid_out <= 1'b1;
      cbfp_index     <= idx_r[rd_sel_r];
      for (int i = 0; i < LANES; i++)
        out_r[i] <= norm(mem_r[rd_sel_r][rd_cnt_r][i], idx_r[rd_sel_r]);
    end else begin
      cbfp_valid_out <= 1'b0;
      cbfp_index     <= 5'd0;
      for (int i = 0; i < LANES; i++) out_r[i] <= '0;
    end
  end

  // Unflatten the output lanes into the four output arrays.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cbfp_sum_re[i]  = out_r[i];
      cbfp_sum_im[i]  = out_r[16 + i];
      cbfp_diff_re[i] = out_r[32 + i];
      cbfp_diff_im[i] = out_r[48 + i];
    end
  end

endmodule

// File: tb/tb_cbfp_1.sv
// Directed self-checking bench for cbfp_1 with hand-computed block exponents and outputs.
module tb_cbfp_1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic valid = 1'b0;
  logic signed [24:0] in_v [0:63];
  logic signed [24:0] sum_re [0:15];
  logic signed [24:0] sum_im [0:15];
  logic signed [24:0] diff_re [0:15];
  logic signed [24:0] diff_im [0:15];
  logic signed [12:0] o_sum_re [0:15];
  logic signed [12:0] o_sum_im [0:15];
  logic signed [12:0] o_diff_re [0:15];
  logic signed [12:0] o_diff_im [0:15];
  logic signed [12:0] got [0:63];
  logic signed [12:0] exp_o [0:63];
  logic [4:0] idx;
  logic vout;
  int checks = 0;
  int errors = 0;

  cbfp_1 dut (
    .clk(clk), .rstn(rstn),
    .twd_12_sum_re(sum_re), .twd_12_sum_im(sum_im),
    .twd_12_diff_re(diff_re), .twd_12_diff_im(diff_im),
    .CBFP_valid(valid),
    .cbfp_sum_re(o_sum_re), .cbfp_sum_im(o_sum_im),
    .cbfp_diff_re(o_diff_re), .cbfp_diff_im(o_diff_im),
    .cbfp_index(idx), .cbfp_valid_out(vout)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sum_re[i]  = in_v[i];
      sum_im[i]  = in_v[16 + i];
      diff_re[i] = in_v[32 + i];
      diff_im[i] = in_v[48 + i];
      got[i]      = o_sum_re[i];
      got[16 + i] = o_sum_im[i];
      got[32 + i] = o_diff_re[i];
      got[48 + i] = o_diff_im[i];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input int lane, input logic signed [24:0] v, input logic signed [24:0] fill);
    for (int i = 0; i < 64; i++) in_v[i] = fill;
    if (lane >= 0) in_v[lane] = v;
    valid = 1'b1;
  endtask

  task automatic clear_exp;
    for (int i = 0; i < 64; i++) exp_o[i] = 13'sd0;
  endtask

  task automatic check_beat(input string tag, input int exp_idx);
    chk({tag, "_valid"}, 32'(vout), 32'sd1);
    chk({tag, "_index"}, 32'(idx), 32'(exp_idx));
    for (int i = 0; i < 64; i++) chk($sformatf("%s_lane%0d", tag, i), 32'(got[i]), 32'(exp_o[i]));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(vout), 32'sd0);
    chk({tag, "_index"}, 32'(idx), 32'sd0);
    for (int i = 0; i < 64; i++) chk($sformatf("%s_lane%0d", tag, i), 32'(got[i]), 32'sd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) in_v[i] = 25'sd0;
    clear_exp();
    #2;
    check_idle("reset_async");
    tick(); tick();
    check_idle("reset");
    rstn = 1'b1;
    tick();

    // Single outlier: 4096 among ones -> index 11, 4096 maps to 2048, ones floor to 0.
    drive(3, 25'sd4096, 25'sd1); tick();
    for (int b = 1; b < 4; b++) begin drive(-1, 25'sd0, 25'sd1); tick(); end
    valid = 1'b0;
    check_idle("A_pre");
    clear_exp(); exp_o[3] = 13'sd2048;
    tick(); check_beat("A_b0", 11);
    clear_exp();
    for (int b = 1; b < 4; b++) begin tick(); check_beat($sformatf("A_b%0d", b), 11); end
    tick(); check_idle("A_post");

    // All-zero block: index 24, exactly four zero-valued output beats.
    for (int b = 0; b < 4; b++) begin drive(-1, 25'sd0, 25'sd0); tick(); end
    valid = 1'b0;
    check_idle("Z_pre");
    clear_exp();
    for (int b = 0; b < 4; b++) begin tick(); check_beat($sformatf("Z_b%0d", b), 24); end
    tick(); check_idle("Z_post");

    // Full-scale negative -2^24 at diff_im[7] of beat 2: index 0, output -4096.
    for (int b = 0; b < 4; b++) begin
      if (b == 2) drive(55, 25'sh1000000, 25'sd0);
      else drive(-1, 25'sd0, 25'sd0);
      tick();
    end
    valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      clear_exp();
      if (b == 2) exp_o[55] = 13'h1000;
      tick(); check_beat($sformatf("N_b%0d", b), 0);
    end
    tick(); check_idle("N_post");

    // Back-to-back blocks: A (min_lz 5, with -3 flooring to -1), B (min_lz 20).
    drive(0, -25'sd3, 25'sd0); tick();
    drive(16, 25'sd262144, 25'sd0); tick();
    drive(-1, 25'sd0, 25'sd0); tick();
    drive(-1, 25'sd0, 25'sd0); tick();
    chk("D_pre_valid", 32'(vout), 32'sd0);
    drive(-1, 25'sd0, 25'sd0); tick();
    clear_exp(); exp_o[0] = -13'sd1;
    check_beat("D_a0", 5);
    drive(-1, 25'sd0, 25'sd0); tick();
    clear_exp(); exp_o[16] = 13'sd2048;
    check_beat("D_a1", 5);
    drive(-1, 25'sd0, 25'sd0); tick();
    clear_exp();
    check_beat("D_a2", 5);
    drive(47, 25'sd8, 25'sd0); tick();
    check_beat("D_a3", 5);
    valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      clear_exp();
      if (b == 3) exp_o[47] = 13'sd2048;
      tick(); check_beat($sformatf("D_b%0d", b), 20);
    end
    tick(); check_idle("D_post");

    // Gapped input: outlier block with two idle cycles between valid beats.
    for (int b = 0; b < 4; b++) begin
      if (b == 0) drive(3, 25'sd4096, 25'sd1);
      else drive(-1, 25'sd0, 25'sd1);
      tick();
      valid = 1'b0;
      if (b < 3) begin
        tick(); chk($sformatf("G_gap%0d_valid", b), 32'(vout), 32'sd0);
        tick();
      end
    end
    check_idle("G_pre");
    clear_exp(); exp_o[3] = 13'sd2048;
    tick(); check_beat("G_b0", 11);
    clear_exp();
    for (int b = 1; b < 4; b++) begin tick(); check_beat($sformatf("G_b%0d", b), 11); end
    tick(); check_idle("G_post");

    // Reset during a drain clears outputs immediately.
    drive(0, 25'sh1000000, 25'sd0); tick();
    for (int b = 1; b < 4; b++) begin drive(-1, 25'sd0, 25'sd0); tick(); end
    valid = 1'b0;
    tick();
    chk("R_drain_valid", 32'(vout), 32'sd1);
    #2 rstn = 1'b0;
    #1 check_idle("R_drain_rst");
    tick(); rstn = 1'b1;
    tick(); check_idle("R_drain_after");

    // Reset after two beats of a partial block, then one clean block (min_lz 5).
    drive(0, 25'sh1000000, 25'sd0); tick();
    drive(1, 25'sh1000000, 25'sd0); tick();
    valid = 1'b0;
    #2 rstn = 1'b0;
    #1 check_idle("R_part_rst");
    tick(); rstn = 1'b1;
    tick(); check_idle("R_part_after");
    drive(5, 25'sd262144, 25'sd0); tick();
    for (int b = 1; b < 4; b++) begin drive(-1, 25'sd0, 25'sd0); tick(); end
    valid = 1'b0;
    check_idle("R_pre");
    for (int b = 0; b < 4; b++) begin
      clear_exp();
      if (b == 0) exp_o[5] = 13'sd2048;
      tick(); check_beat($sformatf("R_b%0d", b), 5);
    end
    tick(); check_idle("R_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
